// File: rtl/cxu_mux_n.sv
// cxu_mux_n: CXU-LI one-initiator to N-target mux; responses return in request order via an ID FIFO.
module cxu_mux_n #(
    parameter int unsigned CXU_N_CXUS     = 4,
    parameter int unsigned CXU_CXU_ID_W   = (CXU_N_CXUS > 1) ? $clog2(CXU_N_CXUS) : 1,
    parameter int unsigned CXU_STATE_ID_W = 1,
    parameter int unsigned CXU_FUNC_ID_W  = 3,
    parameter int unsigned CXU_INSN_W     = 1,
    parameter int unsigned CXU_DATA_W     = 32,
    parameter int unsigned N_REQS         = 16,
    parameter logic [2:0]  ERR_STATUS     = 3'd7
) (
    input  logic                               CLK,
    input  logic                               rst,
    input  logic                               UserCLK_en,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [CXU_CXU_ID_W-1:0]            req_cxu,
    input  logic [CXU_STATE_ID_W-1:0]          req_state,
    input  logic [CXU_FUNC_ID_W-1:0]           req_func,
    input  logic [CXU_INSN_W-1:0]              req_insn,
    input  logic [CXU_DATA_W-1:0]              req_data0,
    input  logic [CXU_DATA_W-1:0]              req_data1,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [2:0]                         resp_status,
    output logic [CXU_DATA_W-1:0]              resp_data,
    output logic [CXU_N_CXUS-1:0]              t_req_valid,
    input  logic [CXU_N_CXUS-1:0]              t_req_ready,
    output logic [CXU_STATE_ID_W-1:0]          t_req_state,
    output logic [CXU_FUNC_ID_W-1:0]           t_req_func,
    output logic [CXU_INSN_W-1:0]              t_req_insn,
    output logic [CXU_DATA_W-1:0]              t_req_data0,
    output logic [CXU_DATA_W-1:0]              t_req_data1,
    input  logic [CXU_N_CXUS-1:0]              t_resp_valid,
    output logic [CXU_N_CXUS-1:0]              t_resp_ready,
    input  logic [3*CXU_N_CXUS-1:0]            t_resp_status,
    input  logic [CXU_DATA_W*CXU_N_CXUS-1:0]   t_resp_data
);

    localparam int unsigned ID_W   = CXU_CXU_ID_W;
    localparam int unsigned DATA_W = CXU_DATA_W;
    localparam int unsigned PTR_W  = (N_REQS > 1) ? $clog2(N_REQS) : 1;
    localparam int unsigned CNT_W  = $clog2(N_REQS + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_REQS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_REQS);

    typedef struct packed {
        logic            err;
        logic [ID_W-1:0] id;
    } entry_t;

    entry_t            fifo [N_REQS];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic   en;
    logic   full;
    logic   hit;
    logic   sel_ready;
    logic   push;
    logic   pop;
    entry_t head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Payload is broadcast to every target with no added latency
    assign t_req_state = req_state;
    assign t_req_func  = req_func;
    assign t_req_insn  = req_insn;
    assign t_req_data0 = req_data0;
    assign t_req_data1 = req_data1;

    // Request routing: valid to the selected target only, absent IDs accepted locally
    always_comb begin
        en          = UserCLK_en & ~rst;
        full        = (count == FULL_CNT);
        hit         = 1'b0;
        sel_ready   = 1'b0;
        t_req_valid = '0;
        for (int i = 0; i < int'(CXU_N_CXUS); i++) begin
            if (req_cxu == ID_W'(i)) begin
                hit            = 1'b1;
                sel_ready      = t_req_ready[i];
                t_req_valid[i] = en & req_valid & ~full;
            end
        end
        req_ready = en & ~full & (hit ? sel_ready : 1'b1);
        push      = req_valid & req_ready;
    end

    // Response return: only the FIFO head's target may complete; error entries answer locally
    always_comb begin
        head         = fifo[rd_ptr];
        resp_valid   = 1'b0;
        resp_status  = '0;
        resp_data    = '0;
        t_resp_ready = '0;
        if (!rst && count != '0) begin
            if (head.err) begin
                resp_valid  = en;
                resp_status = ERR_STATUS;
            end else begin
                for (int i = 0; i < int'(CXU_N_CXUS); i++) begin
                    if (head.id == ID_W'(i)) begin
                        resp_valid      = en & t_resp_valid[i];
                        resp_status     = t_resp_status[3*i +: 3];
                        resp_data       = t_resp_data[DATA_W*i +: DATA_W];
                        t_resp_ready[i] = en & resp_ready;
                    end
                end
            end
        end
        pop = resp_valid & resp_ready;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset needed
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo[wr_ptr] <= '{err: ~hit, id: req_cxu};
        end
    end

endmodule
